// File: rtl/cm0_dbg_bpu_dsl.sv
`default_nettype none
// ============================================================================
// Module   : cm0_dbg_bpu_dsl
// Brief    : AHB-Lite PPB slave for the breakpoint register page. It decodes
//            address phases into data-phase BPU selects and a write strobe,
//            returns BPU read data, and answers illegal sizes with an ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module cm0_dbg_bpu_dsl #(
    parameter int BKPT = 4,
    parameter int DBG  = 1
) (
    input  logic        dclk,
    input  logic        dbg_reset_n,
    input  logic        hsel_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [9:0]  haddr_11_2_i,
    input  logic        hready_i,
    input  logic [31:0] hwdata_i,
    input  logic [31:0] bpu_hrdata_i,
    output logic [4:0]  dsl_bpu_sels_o,
    output logic        dsl_ppb_write_o,
    output logic [31:0] slv_wdata_o,
    output logic        hreadyout_o,
    output logic        hresp_o,
    output logic [31:0] hrdata_o
);

    localparam int c_num_comp = (BKPT > 4) ? 4 : ((BKPT < 0) ? 0 : BKPT);
    localparam bit c_dbg_en   = (DBG != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_sels;
    logic        r_write;
    logic        r_read;
    logic        w_accept;
    logic        w_legal;
    logic        w_illegal;
    logic [4:0]  w_dec_sels;
    logic [4:0]  w_sels_nxt;

    // Nothing is accepted during the first error cycle: it always moves on to ERR2.
    assign w_accept  = hsel_i & htrans_i[1] & hready_i & (r_state != ST_ERR1);
    assign w_legal   = w_accept & (hsize_i == 3'b010);
    assign w_illegal = w_accept & c_dbg_en & (hsize_i != 3'b010);

    generate
        if (c_dbg_en && (c_num_comp > 0)) begin : g_ctrl
            assign w_dec_sels[4] = (haddr_11_2_i == 10'h000);
        end else begin : g_no_ctrl
            assign w_dec_sels[4] = 1'b0;
        end

        // Comparator n sits at byte offset 0x008 + 4n, i.e. word offset n + 2.
        for (genvar n = 0; n < 4; n++) begin : g_comp
            localparam logic [9:0] c_off = 10'(n + 2);
            if (c_dbg_en && (n < c_num_comp)) begin : g_present
                assign w_dec_sels[3-n] = (haddr_11_2_i == c_off);
            end else begin : g_absent
                assign w_dec_sels[3-n] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_sels_nxt  = 5'd0;
        if (r_state == ST_ERR1) begin
            w_state_nxt = ST_ERR2;
        end else if (w_illegal) begin
            w_state_nxt = ST_ERR1;
        end else if (w_legal) begin
            w_state_nxt = ST_DATA;
            w_sels_nxt  = w_dec_sels;
        end
    end

    always_ff @(posedge dclk or negedge dbg_reset_n) begin
        if (!dbg_reset_n) begin
            r_state <= ST_IDLE;
            r_sels  <= 5'd0;
            r_write <= 1'b0;
            r_read  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sels  <= w_sels_nxt;
            r_write <= hwrite_i & (|w_sels_nxt);
            r_read  <= ~hwrite_i & (|w_sels_nxt);
        end
    end

    assign dsl_bpu_sels_o  = r_sels;
    assign dsl_ppb_write_o = r_write;
    assign slv_wdata_o     = hwdata_i;
    assign hreadyout_o     = (r_state != ST_ERR1);
    assign hresp_o         = (r_state == ST_ERR1) || (r_state == ST_ERR2);
    assign hrdata_o        = ((r_state == ST_DATA) && r_read) ? bpu_hrdata_i : 32'd0;

endmodule
`default_nettype wire
